// File: rtl/cpu_pkg.sv
// Shared definitions for the basic CPU memory subsystem.
//   - Default address/data/memory widths.
//   - Encoding of the response-owner state held by mem_port_arbiter.
//   - Width of the fetch starvation counter (MAX_WAIT is at most 15).
package cpu_pkg;

    localparam int CPU_ADDR_W = 32;
    localparam int CPU_DATA_W = 32;
    localparam int CPU_MEM_AW = 10;
    localparam int WAIT_CNT_W = 4;

    // Which requester owns the memory response arriving next cycle.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_DRD  = 2'd2,
        OWNER_DWR  = 2'd3
    } resp_owner_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Fetch starvation guard for mem_port_arbiter.
// Counts consecutive cycles in which fetch requested but data won the port.
// Once the count reaches MAX_WAIT, force_if tells the arbiter to give the
// next contested cycle to fetch.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   if_req     fetch request this cycle
//   if_gnt     fetch granted this cycle
//   d_gnt      data granted this cycle
//   wait_cnt   current consecutive-loss count (saturates at MAX_WAIT)
//   force_if   wait_cnt has reached MAX_WAIT
module arb_starve_cnt
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic                  if_gnt,
    input  logic                  d_gnt,
    output logic [WAIT_CNT_W-1:0] wait_cnt,
    output logic                  force_if
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MAX_WAIT);

    assign force_if = (wait_cnt == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            wait_cnt <= '0;
        end else if (d_gnt && !force_if) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and
// load/store. Data wins contested cycles unless fetch has lost MAX_WAIT
// times in a row. One access per cycle; the response comes exactly one
// cycle after the grant.
//
// Handshake: a request is accepted in the cycle where req and gnt are both
// high (gnt is combinational from req); the requester holds req and address
// stable until then. rvalid is a one-cycle pulse with no backpressure, and
// rdata holds its last value while rvalid is low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch request; if_gnt, if_rvalid, if_rdata
//   d_req/d_we/d_addr/d_be/d_wdata   data request; d_gnt, d_rvalid, d_rdata
//   mem_en/we/addr/be/wdata  RAM command; mem_rdata valid the cycle after
//   dbg_owner, dbg_wait_cnt  response-owner state and starvation count
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int DATA_W   = CPU_DATA_W,
    parameter int MEM_AW   = CPU_MEM_AW,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [1:0]            dbg_owner,
    output logic [WAIT_CNT_W-1:0] dbg_wait_cnt
);

    resp_owner_t           owner, owner_nxt;
    logic                  force_if;
    logic [DATA_W-1:0]     if_rdata_q, d_rdata_q;
    logic                  unused_addr_bits;

    // Byte offset and bits above the RAM window are intentionally dropped.
    assign unused_addr_bits = ^{if_addr[ADDR_W-1:MEM_AW+2], if_addr[1:0],
                                d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

    arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .d_gnt    (d_gnt),
        .wait_cnt (dbg_wait_cnt),
        .force_if (force_if)
    );

    // Grants are gated by rst so nothing reaches the RAM during reset.
    assign if_gnt = !rst && if_req && (!d_req || force_if);
    assign d_gnt  = !rst && d_req && !(if_req && force_if);
    assign mem_en = if_gnt || d_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        mem_addr  = if_addr[MEM_AW+1:2];
        if (d_gnt) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_wdata = d_wdata;
            mem_addr  = d_addr[MEM_AW+1:2];
        end else if (if_gnt) begin
            mem_be    = '1;
        end
    end

    // Response-owner FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) owner <= OWNER_NONE;
        else     owner <= owner_nxt;
    end

    // Response-owner FSM: next state follows this cycle's grant.
    always_comb begin
        owner_nxt = OWNER_NONE;
        if (if_gnt)     owner_nxt = OWNER_IF;
        else if (d_gnt) owner_nxt = d_we ? OWNER_DWR : OWNER_DRD;
    end

    assign dbg_owner = owner;

    // Hold registers so rdata keeps its last value between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (owner == OWNER_IF)  if_rdata_q <= mem_rdata;
            if (owner == OWNER_DRD) d_rdata_q  <= mem_rdata;
            if (owner == OWNER_DWR) d_rdata_q  <= '0;
        end
    end

    // mem_rdata is only valid in the cycle after the grant, so the response
    // in that cycle passes it straight through; owner itself is registered.
    always_comb begin
        if_rvalid = (owner == OWNER_IF);
        d_rvalid  = (owner == OWNER_DRD) || (owner == OWNER_DWR);
        if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
        d_rdata   = d_rdata_q;
        if (owner == OWNER_DRD)      d_rdata = mem_rdata;
        else if (owner == OWNER_DWR) d_rdata = '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  dbg_owner;
  logic [3:0]  dbg_wait_cnt;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_AW(10), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_owner(dbg_owner), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous RAM: read data registered, byte-enabled writes
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      ram[4]    <= 32'h0050_0093;
      ram[5]    <= 32'h00A0_0113;
      ram[8]    <= 32'h0000_0000;
      ram[12]   <= 32'h1122_3344;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // scoreboard helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // driver
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [3:0] be,
                       input logic [31:0] wd);
    @(negedge clk);
    if_req = ir; if_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_be = be; d_wdata = wd;
    #1;
  endtask

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic dw; logic [31:0] da; logic [3:0] be; logic [31:0] wd;
    logic        e_ig; logic e_dg; logic [9:0] e_addr; logic e_we; logic [3:0] e_be;
    logic        e_irv; logic [31:0] e_ird;
    logic        e_drv; logic [31:0] e_drd;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [3:0] be, logic [31:0] wd,
                              logic e_ig, logic e_dg, logic [9:0] e_addr, logic e_we,
                              logic [3:0] e_be, logic e_irv, logic [31:0] e_ird,
                              logic e_drv, logic [31:0] e_drd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.be = be; v.wd = wd;
    v.e_ig = e_ig; v.e_dg = e_dg; v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be;
    v.e_irv = e_irv; v.e_ird = e_ird; v.e_drv = e_drv; v.e_drd = e_drd;
    return v;
  endfunction

  int exp_cnt;
  logic prev_if;

  initial begin
    // expected response for each row is from the previous row's grant
    vecs[0] = mk(1, 32'hFFFF_F010, 0, 0, 32'h0,  4'h0, 32'h0,
                 1, 0, 10'd4,  0, 4'hF, 0, 32'h0,         0, 32'h0);
    vecs[1] = mk(0, 32'h0, 1, 1, 32'h20, 4'h3, 32'hAABB_CCDD,
                 0, 1, 10'd8,  1, 4'h3, 1, 32'h0050_0093, 0, 32'h0);
    vecs[2] = mk(0, 32'h0, 1, 0, 32'h22, 4'hF, 32'h0,
                 0, 1, 10'd8,  0, 4'hF, 0, 32'h0050_0093, 1, 32'h0);
    vecs[3] = mk(1, 32'h14, 0, 0, 32'h0, 4'h0, 32'h0,
                 1, 0, 10'd5,  0, 4'hF, 0, 32'h0050_0093, 1, 32'h0000_CCDD);
    vecs[4] = mk(0, 32'h0, 1, 0, 32'h33, 4'hF, 32'h0,
                 0, 1, 10'd12, 0, 4'hF, 1, 32'h00A0_0113, 0, 32'h0000_CCDD);
    vecs[5] = mk(1, 32'h10, 0, 0, 32'h0, 4'h0, 32'h0,
                 1, 0, 10'd4,  0, 4'hF, 0, 32'h00A0_0113, 1, 32'h1122_3344);
    vecs[6] = mk(1, 32'h14, 1, 0, 32'h30, 4'hF, 32'h0,
                 0, 1, 10'd12, 0, 4'hF, 1, 32'h0050_0093, 0, 32'h1122_3344);
    vecs[7] = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0,
                 0, 0, 10'd0,  0, 4'h0, 0, 32'h0050_0093, 1, 32'h1122_3344);
    vecs[8] = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0,
                 0, 0, 10'd0,  0, 4'h0, 0, 32'h0050_0093, 0, 32'h1122_3344);

    // reset with both requests held
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; d_be = 4'hF; d_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_if_gnt", {31'h0, if_gnt}, 32'h0);
      chk("rst_d_gnt",  {31'h0, d_gnt},  32'h0);
      chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    #1;
    chk("post_rst_if_rvalid", {31'h0, if_rvalid}, 32'h0);
    chk("post_rst_d_rvalid",  {31'h0, d_rvalid},  32'h0);
    chk("post_rst_if_rdata",  if_rdata, 32'h0);
    chk("post_rst_d_rdata",   d_rdata,  32'h0);
    chk("post_rst_owner",     {30'h0, dbg_owner}, 32'h0);
    chk("post_rst_wait_cnt",  {28'h0, dbg_wait_cnt}, 32'h0);

    // table-driven vectors
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].be, vecs[i].wd);
      chk($sformatf("v%0d_if_gnt", i), {31'h0, if_gnt}, {31'h0, vecs[i].e_ig});
      chk($sformatf("v%0d_d_gnt", i),  {31'h0, d_gnt},  {31'h0, vecs[i].e_dg});
      chk($sformatf("v%0d_mem_en", i), {31'h0, mem_en}, {31'h0, vecs[i].e_ig | vecs[i].e_dg});
      chk($sformatf("v%0d_mem_we", i), {31'h0, mem_we}, {31'h0, vecs[i].e_we});
      chk($sformatf("v%0d_mem_be", i), {28'h0, mem_be}, {28'h0, vecs[i].e_be});
      if (vecs[i].e_ig | vecs[i].e_dg) begin
        chk($sformatf("v%0d_mem_addr", i), {22'h0, mem_addr}, {22'h0, vecs[i].e_addr});
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_dg ? vecs[i].wd : 32'h0);
      end
      chk($sformatf("v%0d_if_rvalid", i), {31'h0, if_rvalid}, {31'h0, vecs[i].e_irv});
      chk($sformatf("v%0d_if_rdata", i),  if_rdata, vecs[i].e_ird);
      chk($sformatf("v%0d_d_rvalid", i),  {31'h0, d_rvalid}, {31'h0, vecs[i].e_drv});
      chk($sformatf("v%0d_d_rdata", i),   d_rdata, vecs[i].e_drd);
    end

    // starvation: both requesting continuously -> D,D,D,D,IF repeating
    exp_cnt = 0;
    prev_if = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 32'h10, 1, 0, 32'h30, 4'hF, 32'h0);
      chk($sformatf("st%0d_wait_cnt", i), {28'h0, dbg_wait_cnt}, exp_cnt);
      chk($sformatf("st%0d_if_gnt", i), {31'h0, if_gnt}, (exp_cnt == 4) ? 32'h1 : 32'h0);
      chk($sformatf("st%0d_d_gnt", i),  {31'h0, d_gnt},  (exp_cnt == 4) ? 32'h0 : 32'h1);
      if (i > 0) begin
        chk($sformatf("st%0d_if_rvalid", i), {31'h0, if_rvalid}, {31'h0, prev_if});
        chk($sformatf("st%0d_d_rvalid", i),  {31'h0, d_rvalid},  {31'h0, !prev_if});
        chk($sformatf("st%0d_rdata", i), prev_if ? if_rdata : d_rdata,
            prev_if ? 32'h0050_0093 : 32'h1122_3344);
      end
      prev_if = (exp_cnt == 4);
      exp_cnt = (exp_cnt == 4) ? 0 : exp_cnt + 1;
    end
    // dropping if_req clears the counter
    drive(0, 32'h0, 1, 0, 32'h30, 4'hF, 32'h0);
    chk("clr_cnt_before", {28'h0, dbg_wait_cnt}, 32'd2);
    drive(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
    chk("clr_cnt_after", {28'h0, dbg_wait_cnt}, 32'd0);

    // reset in the cycle after a load grant
    drive(0, 32'h0, 1, 0, 32'h30, 4'hF, 32'h0);
    chk("rl_d_gnt", {31'h0, d_gnt}, 32'h1);
    @(negedge clk);
    rst = 1'b1; d_req = 1'b0;
    #1;
    chk("rl_d_rvalid_in_rst", {31'h0, d_rvalid}, 32'h0);
    chk("rl_d_rdata_in_rst",  d_rdata, 32'h0);
    chk("rl_owner_in_rst",    {30'h0, dbg_owner}, 32'h0);
    drive(1, 32'h10, 1, 0, 32'h30, 4'hF, 32'h0);
    chk("rl_mem_en_in_rst", {31'h0, mem_en}, 32'h0);
    chk("rl_d_rvalid_in_rst2", {31'h0, d_rvalid}, 32'h0);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    #1;
    chk("rl_d_rvalid_rel", {31'h0, d_rvalid}, 32'h0);
    drive(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
    chk("rl_d_rvalid_rel2", {31'h0, d_rvalid}, 32'h0);
    drive(0, 32'h0, 1, 0, 32'h30, 4'hF, 32'h0);
    chk("rl_reload_gnt", {31'h0, d_gnt}, 32'h1);
    drive(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
    chk("rl_reload_rvalid", {31'h0, d_rvalid}, 32'h1);
    chk("rl_reload_rdata",  d_rdata, 32'h1122_3344);
    drive(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
    chk("rl_reload_pulse_end", {31'h0, d_rvalid}, 32'h0);
    chk("rl_reload_hold", d_rdata, 32'h1122_3344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time bound
  initial begin
    #100000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous instruction/data RAM between the fetch stage and the load/store stage of the basic CPU.
- Sits between the CPU control/datapath and the unified memory.
- Fixed priority to data accesses, with a starvation guard that forces a fetch grant after MAX_WAIT consecutive losses.
- Pipelined: accepts one request per cycle; read data returns exactly one cycle after grant.

Parameters:
- ADDR_W, 32, byte-address width from the CPU.
- DATA_W, 32, data word width; byte enables are DATA_W/8.
- MEM_AW, 10, memory word-address width; mem_addr = addr[MEM_AW+1:2].
- MAX_WAIT, 4, consecutive fetch losses before fetch is forced to win (1..15).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- if_req  input  1  fetch request
- if_addr  input  ADDR_W  fetch byte address
- if_gnt  output  1  fetch accepted this cycle
- if_rvalid  output  1  fetch data valid
- if_rdata  output  DATA_W  fetched instruction
- d_req  input  1  data request
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data byte address
- d_be  input  DATA_W/8  store byte enables
- d_wdata  input  DATA_W  store data
- d_gnt  output  1  data accepted this cycle
- d_rvalid  output  1  load data valid / store acknowledge
- d_rdata  output  DATA_W  load data; 0 for store acks
- mem_en  output  1  RAM access enable
- mem_we  output  1  RAM write enable
- mem_addr  output  MEM_AW  RAM word address
- mem_be  output  DATA_W/8  RAM byte enables
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_en

Behaviour:
- Reset (async assert, sync release): if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, wait_cnt=0, resp_owner=NONE. While rst=1, if_gnt, d_gnt and mem_en are forced to 0.
- Grant logic is combinational within the request cycle N:
  - Only d_req: d_gnt=1.
  - Only if_req: if_gnt=1.
  - Both: d_gnt=1, unless wait_cnt==MAX_WAIT, in which case if_gnt=1.
  - At most one grant per cycle. mem_en = if_gnt|d_gnt.
- Memory drive in the grant cycle:
  - Fetch grant: mem_we=0, mem_be=all ones, mem_wdata=0.
  - Data grant: mem_we=d_we, mem_be=d_be, mem_wdata=d_wdata.
  - No grant: mem_we=0, mem_be=0.
- Address bits [1:0] are ignored; no misalignment fault. Address bits above MEM_AW+1 are dropped.
- Response, registered, at cycle N+1:
  - Fetch: if_rvalid=1, if_rdata=mem_rdata.
  - Data load: d_rvalid=1, d_rdata=mem_rdata.
  - Data store: d_rvalid=1, d_rdata=0.
  - rvalid is a single-cycle pulse. rdata holds its last value when rvalid=0.
- State machine, resp_owner register, updated every cycle from the grant:
  - NONE: no response next cycle.
  - IF: fetch response next cycle.
  - DRD: load response next cycle.
  - DWR: store ack next cycle.
  - Back-to-back grants chain without idle cycles.
- Starvation counter wait_cnt:
  - Increments when if_req=1 and d_gnt=1, saturating at MAX_WAIT.
  - Clears on if_gnt or when if_req=0.
  - Unchanged otherwise.
- No backpressure on responses; requesters must accept rvalid.
- Requesters must hold req and address stable until gnt.
- Reset mid-operation: a pending response is discarded, with no rvalid after reset release.

Decomposition:
- Shared package cpu_pkg holds:
  - resp_owner encoding (NONE=2'd0, IF=2'd1, DRD=2'd2, DWR=2'd3).
  - Default ADDR_W, DATA_W and MEM_AW constants.
- One natural sub-module: arb_starve_cnt (saturating wait counter plus force flag).
- Grant and response logic stay in the top module.

Test Plan:
- Reset with if_req=1, d_req=1 held -> no grants and no mem_en while rst=1; all rvalid and rdata = 0 after release.
- Fetch only, if_addr=0x10, RAM[4]=0x00500093 -> if_gnt in cycle N, mem_addr=4, if_rvalid=1 with if_rdata=0x00500093 in cycle N+1.
- Store d_addr=0x20, d_be=4'b0011, d_wdata=0xAABBCCDD, then load 0x20 with prior RAM[8]=0 -> store ack with d_rdata=0; load returns 0x0000CCDD.
- Both requesting continuously with MAX_WAIT=4 -> grant pattern D,D,D,D,IF repeating; wait_cnt returns to 0 after each IF grant.
- Alternating single-cycle grants IF,D,IF -> rvalid pulses one cycle later each, with no dropped or swapped data.
- Assert rst in the cycle after a load grant -> no d_rvalid during or after reset; the next load after release completes normally.
